harmonic_adder: RTL and testbench

//   Sequential harmonic-series accumulator: on start, computes H(n) = sum 1/i for i=1..n.
//   n is a 4-bit operand (0..15). Result is unsigned fixed point Q3.16 on a 19-bit bus.

---
 rtl/harmonic_pkg.sv | 10 +
 rtl/harmonic_adder_recip_rom.sv | 21 ++
 rtl/harmonic_adder.sv | 56 +++++
 tb/tb_harmonic_adder.sv | 105 ++++++++++
 4 files changed

// File: rtl/harmonic_pkg.sv
// harmonic_pkg: shared widths, FSM state encoding and sum type for the harmonic-series accumulator.
package harmonic_pkg;
    localparam int FRAC_W  = 16;
    localparam int INT_W   = 3;
    localparam int N_W     = 4;
    localparam int SUM_W   = INT_W + FRAC_W;
    localparam int RECIP_W = FRAC_W + 1;
    typedef enum logic [1:0] {IDLE, INIT, ACC, HOLD} state_t;
    typedef logic [SUM_W-1:0] sum_t;
endpackage

// File: rtl/harmonic_adder_recip_rom.sv
// recip_rom: 4-bit index to 17-bit Q1.16 reciprocal of the index; index 0 yields 0.
// HA_ROUND_EN selects round-to-nearest contents instead of truncated ones.
module recip_rom
    import harmonic_pkg::*;
(
    input  logic [N_W-1:0]     i_idx,
    output logic [RECIP_W-1:0] o_recip
);
`ifdef HA_ROUND_EN
    localparam logic [RECIP_W-1:0] TABLE [16] = '{
        17'd0,     17'd65536, 17'd32768, 17'd21845, 17'd16384, 17'd13107, 17'd10923, 17'd9362,
        17'd8192,  17'd7282,  17'd6554,  17'd5958,  17'd5461,  17'd5041,  17'd4681,  17'd4369
    };
`else
    localparam logic [RECIP_W-1:0] TABLE [16] = '{
        17'd0,     17'd65536, 17'd32768, 17'd21845, 17'd16384, 17'd13107, 17'd10922, 17'd9362,
        17'd8192,  17'd7281,  17'd6553,  17'd5957,  17'd5461,  17'd5041,  17'd4681,  17'd4369
    };
`endif
    assign o_recip = TABLE[i_idx];
endmodule

// File: rtl/harmonic_adder.sv
// harmonic_adder: sequential H(n) = sum 1/i accumulator in Q3.16, one term per clock.
// Define HA_ROUND_EN for rounded reciprocals; ports and timing do not change.
module harmonic_adder
    import harmonic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic [SUM_W-1:0] sum
);
    state_t             r_state;
    state_t             w_next;
    logic [N_W-1:0]     r_i;
    logic [N_W-1:0]     r_n;
    logic [RECIP_W-1:0] w_recip;
    sum_t               r_sum;

    recip_rom u_rom (
        .i_idx  (r_i),
        .o_recip(w_recip)
    );

    // HOLD waits for start to drop so a level-held request never retriggers
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? INIT : IDLE;
            INIT:    w_next = (n == '0) ? HOLD : ACC;
            ACC:     w_next = (r_i == r_n) ? HOLD : ACC;
            HOLD:    w_next = start ? HOLD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_n     <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == INIT) begin
                r_n   <= n;
                r_i   <= N_W'(1);
                r_sum <= '0;
            end else if (r_state == ACC) begin
                r_sum <= r_sum + {{(SUM_W-RECIP_W){1'b0}}, w_recip};
                r_i   <= r_i + 1'b1;
            end
        end
    end

    assign sum = r_sum;
endmodule

// File: tb/tb_harmonic_adder.sv
// tb_harmonic_adder: randomized and directed checks of harmonic_adder against an arithmetic H(n) model.
module tb_harmonic_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  n = 4'd0;
    logic [18:0] sum;
    int          checks = 0;
    int          failures = 0;

    harmonic_adder dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .n    (n),
        .sum  (sum)
    );

    always #5 clk = ~clk;

    function automatic int h_ref(input int nn);
        int s = 0;
        for (int i = 1; i <= nn; i++)
`ifdef HA_ROUND_EN
            s += (131072 + i) / (2 * i);
`else
            s += 65536 / i;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // start held for slen edges; n is scrambled once INIT has latched it
    task automatic run(input int nn, input int slen, input string tag);
        @(negedge clk);
        n = 4'(nn);
        start = 1'b1;
        for (int k = 1; k <= nn + 2; k++) begin
            @(posedge clk);
            #1;
            if (k >= slen) start = 1'b0;
            if (k >= 2) n = 4'($urandom);
        end
        chk(tag, int'(sum), h_ref(nn));
        repeat (3) @(posedge clk);
        #1 chk({tag, "_hold"}, int'(sum), h_ref(nn));
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk({tag, "_idle"}, int'(sum), h_ref(nn));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_sum", int'(sum), 0);
        @(negedge clk) reset = 1'b0;

        run(6, 3, "n6");
`ifdef HA_ROUND_EN
        chk("n6_const", int'(sum), 160563);
`else
        chk("n6_const", int'(sum), 160562);
`endif
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset_idle", int'(sum), 0);
        @(negedge clk) reset = 1'b0;

        run(2, 1, "n2");
        chk("n2_const", int'(sum), 98304);
        run(0, 6, "n0");
        run(15, 1, "n15");
`ifndef HA_ROUND_EN
        chk("n15_const", int'(sum), 217459);
`endif

        @(negedge clk);
        n = 4'd15;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset_acc", int'(sum), 0);
        start = 1'b0;
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_stays_idle", int'(sum), 0);
        run(1, 1, "n1");
        chk("n1_const", int'(sum), 65536);

        for (int t = 0; t < 24; t++) begin
            int nn;
            nn = int'($urandom_range(0, 15));
            run(nn, int'($urandom_range(1, nn + 5)), $sformatf("rand%0d_n%0d", t, nn));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
